// File: rtl/div_pkg.sv
// Shared types and constants for the TinyTapeout sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DW   = 8;
    localparam int VW   = 4;
    localparam int CNTW = 3;

    localparam logic [7:0] UIO_OE_VAL = 8'hC0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
(
    input  logic [VW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [VW-1:0] i_div,
    output logic [VW-1:0] o_rem,
    output logic          o_qbit
);

    logic [VW:0] w_r5;

    assign w_r5   = {i_rem, i_bit};
    assign o_qbit = (w_r5 >= {1'b0, i_div});
    // When the divisor fits, the difference is always below the divisor, so it fits in VW bits.
    assign o_rem  = o_qbit ? VW'(w_r5 - {1'b0, i_div}) : w_r5[VW-1:0];

endmodule

// File: rtl/tt_um_b_5_seq_divider.sv
// 8-bit / 4-bit sequential restoring divider on the TinyTapeout pin frame.
// Define DIVZERO_FAST_EN to finish a divide-by-zero at the load edge (q=FF, r=F).
module tt_um_b_5_seq_divider
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t          r_state;
    state_t          w_next_state;
    logic [DW-1:0]   r_q_work;
    logic [VW-1:0]   r_rem_work;
    logic [VW-1:0]   r_div;
    logic [CNTW-1:0] r_cnt;
    logic [DW-1:0]   r_quot;
    logic [VW-1:0]   r_rem;

    logic            w_start;
    logic            w_rsel;
    logic            w_last;
    logic            w_fast_zero;
    logic            w_qbit;
    logic [VW-1:0]   w_rem_next;
    logic [DW-1:0]   w_q_next;
    logic            w_unused;

    assign w_start  = uio_in[4];
    assign w_rsel   = uio_in[5];
    assign w_last   = (r_cnt == CNTW'(DW - 1));
    assign w_q_next = {r_q_work[DW-2:0], w_qbit};
    assign w_unused = &{1'b0, ena, uio_in[7:6]};

`ifdef DIVZERO_FAST_EN
    assign w_fast_zero = (uio_in[VW-1:0] == '0);
`else
    assign w_fast_zero = 1'b0;
`endif

    div_step u_step (
        .i_rem  (r_rem_work),
        .i_bit  (r_q_work[DW-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_next_state = w_fast_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operands are latched at launch so the pins may change freely while the divide runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_work   <= '0;
            r_rem_work <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_q_work   <= ui_in;
                        r_div      <= uio_in[VW-1:0];
                        r_rem_work <= '0;
                        r_cnt      <= '0;
                        if (w_fast_zero) begin
                            r_quot <= '1;
                            r_rem  <= '1;
                        end
                    end
                end
                S_RUN: begin
                    r_q_work   <= w_q_next;
                    r_rem_work <= w_rem_next;
                    r_cnt      <= r_cnt + CNTW'(1);
                    if (w_last) begin
                        r_quot <= w_q_next;
                        r_rem  <= w_rem_next;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign uo_out  = w_rsel ? {{(DW - VW){1'b0}}, r_rem} : r_quot;
    assign uio_out = {(r_state == S_RUN), (r_state == S_DONE), 6'b000000};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_b_5_seq_divider.sv
// Self-checking bench for the sequential divider; expectations come from plain
// integer division (and the DIVZERO_FAST_EN rule when that macro is defined).
module tb_tt_um_b_5_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_b_5_seq_divider dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void ref_div(input logic [7:0] a, input logic [3:0] b,
                                    output logic [7:0] q, output logic [3:0] r,
                                    output int lat);
        logic [7:0] rr;
        if (b != 4'd0) begin
            q   = a / {4'b0000, b};
            rr  = a % {4'b0000, b};
            r   = rr[3:0];
            lat = 9;
        end else begin
`ifdef DIVZERO_FAST_EN
            q   = 8'hFF;
            r   = 4'hF;
            lat = 1;
`else
            q   = 8'hFF;
            r   = a[3:0];
            lat = 9;
`endif
        end
    endfunction

    task automatic read_result(output logic [7:0] q, output logic [7:0] rfull);
        uio_in[5] = 1'b0;
        #1 q = uo_out;
        uio_in[5] = 1'b1;
        #1 rfull = uo_out;
        uio_in[5] = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int edges);
        @(negedge clk);
        ui_in       = a;
        uio_in[3:0] = b;
        uio_in[4]   = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            uio_in[4] = 1'b0;
        end while (uio_out[6] !== 1'b1 && edges < 20);
    endtask

    task automatic test_reset();
        logic [7:0] q, rf;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        read_result(q, rf);
        checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_uio_out got=%h exp=00", uio_out); end
        checks++; if (uio_oe !== 8'hC0) begin errors++; $display("[TB] FAIL reset_uio_oe got=%h exp=c0", uio_oe); end
        checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_quot got=%h exp=00", q); end
        checks++; if (rf !== 8'h00) begin errors++; $display("[TB] FAIL reset_rem got=%h exp=00", rf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL idle_after_reset got=%h exp=00", uio_out); end
    endtask

    task automatic test_basic();
        logic [7:0] q, rf, eq;
        logic [3:0] er;
        int lat, edges;
        logic [7:0] av [3] = '{8'd255, 8'd13, 8'd0};
        logic [3:0] bv [3] = '{4'd15, 4'd14, 4'd5};
        @(negedge clk);
        ui_in       = 8'd200;
        uio_in[3:0] = 4'd7;
        uio_in[4]   = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            uio_in[4] = 1'b0;
            checks++;
            if (uio_out[7] !== (cyc <= 8)) begin
                errors++; $display("[TB] FAIL busy_200_7 cycle=%0d got=%b exp=%b", cyc, uio_out[7], (cyc <= 8));
            end
            checks++;
            if (uio_out[6] !== (cyc == 9)) begin
                errors++; $display("[TB] FAIL done_200_7 cycle=%0d got=%b exp=%b", cyc, uio_out[6], (cyc == 9));
            end
        end
        read_result(q, rf);
        checks++; if (q !== 8'd28) begin errors++; $display("[TB] FAIL quot_200_7 got=%0d exp=28", q); end
        checks++; if (rf !== 8'd4) begin errors++; $display("[TB] FAIL rem_200_7 got=%0d exp=4", rf); end
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], edges);
            ref_div(av[i], bv[i], eq, er, lat);
            read_result(q, rf);
            checks++; if (edges != lat) begin errors++; $display("[TB] FAIL lat_%0d_%0d got=%0d exp=%0d", av[i], bv[i], edges, lat); end
            checks++; if (q !== eq) begin errors++; $display("[TB] FAIL quot_%0d_%0d got=%0d exp=%0d", av[i], bv[i], q, eq); end
            checks++; if (rf !== {4'b0000, er}) begin errors++; $display("[TB] FAIL rem_%0d_%0d got=%0d exp=%0d", av[i], bv[i], rf, er); end
        end
    endtask

    task automatic test_divzero();
        logic [7:0] q, rf, eq;
        logic [3:0] er;
        int lat, edges;
        logic saw_busy;
        ref_div(8'hA5, 4'd0, eq, er, lat);
        @(negedge clk);
        ui_in       = 8'hA5;
        uio_in[3:0] = 4'd0;
        uio_in[4]   = 1'b1;
        edges    = 0;
        saw_busy = 1'b0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            uio_in[4] = 1'b0;
            if (uio_out[7] === 1'b1) saw_busy = 1'b1;
        end while (uio_out[6] !== 1'b1 && edges < 20);
        read_result(q, rf);
        checks++; if (edges != lat) begin errors++; $display("[TB] FAIL divzero_lat got=%0d exp=%0d", edges, lat); end
        checks++; if (saw_busy !== (lat != 1)) begin errors++; $display("[TB] FAIL divzero_busy got=%b exp=%b", saw_busy, (lat != 1)); end
        checks++; if (q !== eq) begin errors++; $display("[TB] FAIL divzero_quot got=%h exp=%h", q, eq); end
        checks++; if (rf !== {4'b0000, er}) begin errors++; $display("[TB] FAIL divzero_rem got=%h exp=%h", rf, er); end
    endtask

    task automatic test_ignore_start();
        logic [7:0] q, rf;
        int edges;
        run_op(8'd77, 4'd5, edges);
        read_result(q, rf);
        checks++; if (q !== 8'd15 || rf !== 8'd2) begin errors++; $display("[TB] FAIL prior_77_5 got q=%0d r=%0d exp q=15 r=2", q, rf); end
        @(negedge clk);
        ui_in       = 8'd100;
        uio_in[3:0] = 4'd3;
        uio_in[4]   = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) uio_in[4] = 1'b0;
            if (edges == 3) begin
                ui_in       = 8'h11;
                uio_in[3:0] = 4'd9;
                uio_in[4]   = 1'b1;
            end
            if (edges == 6) uio_in[4] = 1'b0;
            if (edges >= 2 && edges <= 8) begin
                read_result(q, rf);
                checks++;
                if (q !== 8'd15 || rf !== 8'd2) begin
                    errors++; $display("[TB] FAIL held_result edge=%0d got q=%0d r=%0d exp q=15 r=2", edges, q, rf);
                end
            end
        end while (uio_out[6] !== 1'b1 && edges < 20);
        read_result(q, rf);
        checks++; if (edges != 9) begin errors++; $display("[TB] FAIL lat_100_3 got=%0d exp=9", edges); end
        checks++; if (q !== 8'd33) begin errors++; $display("[TB] FAIL quot_100_3 got=%0d exp=33", q); end
        checks++; if (rf !== 8'd1) begin errors++; $display("[TB] FAIL rem_100_3 got=%0d exp=1", rf); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] q, rf;
        int edges;
        @(negedge clk);
        ui_in       = 8'd200;
        uio_in[3:0] = 4'd7;
        uio_in[4]   = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            uio_in[4] = 1'b0;
        end
        checks++; if (uio_out[7] !== 1'b1) begin errors++; $display("[TB] FAIL busy_before_reset got=%b exp=1", uio_out[7]); end
        rst_n = 1'b0;
        read_result(q, rf);
        checks++; if (uio_out !== 8'h00) begin errors++; $display("[TB] FAIL midop_reset_flags got=%h exp=00", uio_out); end
        checks++; if (q !== 8'h00 || rf !== 8'h00) begin errors++; $display("[TB] FAIL midop_reset_result got q=%h r=%h exp 00", q, rf); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd50, 4'd6, edges);
        read_result(q, rf);
        checks++; if (edges != 9) begin errors++; $display("[TB] FAIL lat_50_6 got=%0d exp=9", edges); end
        checks++; if (q !== 8'd8 || rf !== 8'd2) begin errors++; $display("[TB] FAIL result_50_6 got q=%0d r=%0d exp q=8 r=2", q, rf); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, rf, eq;
        logic [3:0] er;
        int lat, k, since;
        logic [7:0] av [3] = '{8'd200, 8'd255, 8'd100};
        logic [3:0] bv [3] = '{4'd7, 4'd15, 4'd3};
        @(negedge clk);
        ui_in       = av[0];
        uio_in[3:0] = bv[0];
        uio_in[4]   = 1'b1;
        k = 0;
        since = 0;
        for (int e = 0; e < 40 && k < 3; e++) begin
            @(posedge clk);
            since++;
            @(negedge clk);
            if (uio_out[6] === 1'b1) begin
                ref_div(av[k], bv[k], eq, er, lat);
                read_result(q, rf);
                checks++; if (since != lat) begin errors++; $display("[TB] FAIL b2b_spacing op=%0d got=%0d exp=%0d", k, since, lat); end
                checks++; if (q !== eq || rf !== {4'b0000, er}) begin
                    errors++; $display("[TB] FAIL b2b_result op=%0d got q=%0d r=%0d exp q=%0d r=%0d", k, q, rf, eq, er);
                end
                k++;
                since = 0;
                if (k < 3) begin
                    ui_in       = av[k];
                    uio_in[3:0] = bv[k];
                end else begin
                    uio_in[4] = 1'b0;
                end
            end
        end
        uio_in[4] = 1'b0;
        checks++; if (k != 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", k); end
    endtask

    task automatic test_random_sweep();
        logic [7:0] q, rf, eq, a;
        logic [3:0] er, b;
        logic [11:0] p;
        int lat, edges;
        int unsigned off;
        off = $urandom;
        for (int i = 0; i < 4096; i++) begin
            p = 12'(int'(off) + i);
            a = p[11:4];
            b = p[3:0];
            run_op(a, b, edges);
            ref_div(a, b, eq, er, lat);
            read_result(q, rf);
            checks++; if (edges != lat) begin errors++; $display("[TB] FAIL sweep_lat %0d/%0d got=%0d exp=%0d", a, b, edges, lat); end
            checks++; if (q !== eq || rf !== {4'b0000, er}) begin
                errors++; $display("[TB] FAIL sweep_result %0d/%0d got q=%0d r=%0d exp q=%0d r=%0d", a, b, q, rf, eq, er);
            end
            if (b != 4'd0) begin
                checks++;
                if ((int'(q) * int'(b) + int'(rf)) != int'(a) || int'(rf) >= int'(b)) begin
                    errors++; $display("[TB] FAIL sweep_invariant %0d/%0d got q=%0d r=%0d", a, b, q, rf);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divzero();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
